// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: handshake states and the
// largest supported source count.
package intr_ctrl_pkg;

    localparam int MAX_SRC = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_e;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set
// and the index of the lowest set bit.
module intr_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = W'(i);
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller for the RAT MCU: pending/mask/global-enable, fixed
// priority selection, and the request/acknowledge/return handshake.
// Define INTR_CTRL_EDGE_EN for rising-edge-triggered IRQ lines; otherwise the
// lines are level-sensitive and no edge-history register is built.
module intr_ctrl #(
    parameter int N_SRC = 4,
    parameter int VEC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_SRC-1:0] IRQ,
    input  logic             MASK_WE,
    input  logic [N_SRC-1:0] MASK_DIN,
    input  logic             SEI,
    input  logic             CLI,
    input  logic             INT_ACK,
    input  logic             RETIE,
    output logic             INT,
    output logic [VEC_W-1:0] VEC,
    output logic             IE,
    output logic [N_SRC-1:0] PEND
);
    import intr_ctrl_pkg::*;

    if (N_SRC < 1 || N_SRC > MAX_SRC) begin : g_bad_cfg
        $error("intr_ctrl: N_SRC out of range");
    end

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [N_SRC-1:0]   pend_q, pend_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic               ie_q, ie_d;

    logic [N_SRC-1:0]   req_set;
    logic [N_SRC-1:0]   ack_clr;
    logic               ack_hit;
    logic               win_vld;
    logic [VEC_W-1:0]   win_idx;

`ifdef INTR_CTRL_EDGE_EN
    logic [N_SRC-1:0]   irq_prev_q;

    // Previous IRQ sample; all ones at reset so a line held high never fires.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) irq_prev_q <= '1;
        else     irq_prev_q <= IRQ;
    end

    assign req_set = IRQ & ~irq_prev_q;
`else
    assign req_set = IRQ;
`endif

    intr_prio_enc #(.N(N_SRC), .W(VEC_W)) u_prio (
        .req_i   (pend_q & mask_q),
        .valid_o (win_vld),
        .idx_o   (win_idx)
    );

    assign ack_hit = (state_q == REQ) && INT_ACK;

    // Pending update: acknowledge clears the granted bit, a new request wins.
    always_comb begin
        ack_clr = '0;
        if (ack_hit) ack_clr[vec_q] = 1'b1;
        pend_d = (pend_q & ~ack_clr) | req_set;
        mask_d = MASK_WE ? MASK_DIN : mask_q;
    end

    // Global enable: RETIE over CLI/INT_ACK over SEI.
    always_comb begin
        ie_d = ie_q;
        if (RETIE)              ie_d = 1'b1;
        else if (CLI || INT_ACK) ie_d = 1'b0;
        else if (SEI)           ie_d = 1'b1;
    end

    // Handshake FSM: grant latched on entry to REQ and never re-arbitrated.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        unique case (state_q)
            IDLE: begin
                if (ie_q && win_vld) begin
                    vec_d   = win_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (INT_ACK)                    state_d = SVC;
                else if (!ie_q || !mask_q[vec_q]) state_d = IDLE;
            end
            SVC: begin
                if (RETIE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // All controller state; reset discards pending work immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            vec_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            ie_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            ie_q    <= ie_d;
        end
    end

    assign INT  = (state_q == REQ);
    assign VEC  = vec_q;
    assign IE   = ie_q;
    assign PEND = pend_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: mode-specific reset/hold sequence,
// a hand-derived vector table, an asynchronous reset check, and a random
// run against a behavioural model.
module tb_intr_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] IRQ = '0;
    logic       MASK_WE = 1'b0;
    logic [3:0] MASK_DIN = '0;
    logic       SEI = 1'b0, CLI = 1'b0, INT_ACK = 1'b0, RETIE = 1'b0;
    logic       INT;
    logic [1:0] VEC;
    logic       IE;
    logic [3:0] PEND;

    int nvec = 0;
    int nmis = 0;

    always #5 CLK = ~CLK;

    intr_ctrl #(.N_SRC(4)) dut (
        .CLK(CLK), .RST(RST), .IRQ(IRQ), .MASK_WE(MASK_WE), .MASK_DIN(MASK_DIN),
        .SEI(SEI), .CLI(CLI), .INT_ACK(INT_ACK), .RETIE(RETIE),
        .INT(INT), .VEC(VEC), .IE(IE), .PEND(PEND)
    );

    typedef struct {
        logic [3:0] irq;
        logic       we;
        logic [3:0] din;
        logic       sei, cli, ack, retie;
        logic       e_int;
        logic [1:0] e_vec;
        logic       e_ie;
        logic [3:0] e_pend;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] irq, input logic we, input logic [3:0] din,
                                input logic sei, input logic cli, input logic ack, input logic retie,
                                input logic ei, input logic [1:0] ev, input logic eie, input logic [3:0] ep);
        vec_t v;
        v.irq = irq; v.we = we; v.din = din; v.sei = sei; v.cli = cli; v.ack = ack; v.retie = retie;
        v.e_int = ei; v.e_vec = ev; v.e_ie = eie; v.e_pend = ep;
        return v;
    endfunction

    // VEC is only meaningful while INT is high.
    task automatic check(input string nm, input logic ei, input logic [1:0] ev, input logic eie, input logic [3:0] ep);
        nvec++;
        if (INT !== ei || (ei && VEC !== ev) || IE !== eie || PEND !== ep) begin
            nmis++;
            $display("FAIL %s @%0t: got INT=%b VEC=%0d IE=%b PEND=%b, want INT=%b VEC=%0d IE=%b PEND=%b",
                     nm, $time, INT, VEC, IE, PEND, ei, ev, eie, ep);
        end
    endtask

    task automatic check_rst(input string nm);
        nvec++;
        if (INT !== 1'b0 || VEC !== 2'd0 || IE !== 1'b0 || PEND !== 4'd0) begin
            nmis++;
            $display("FAIL %s @%0t: got INT=%b VEC=%0d IE=%b PEND=%b, want all zero",
                     nm, $time, INT, VEC, IE, PEND);
        end
    endtask

    task automatic drive(input vec_t v);
        IRQ = v.irq; MASK_WE = v.we; MASK_DIN = v.din;
        SEI = v.sei; CLI = v.cli; INT_ACK = v.ack; RETIE = v.retie;
    endtask

    task automatic run(input vec_t v, input string nm);
        drive(v);
        @(posedge CLK); #1;
        check(nm, v.e_int, v.e_vec, v.e_ie, v.e_pend);
    endtask

    task automatic do_reset(input logic [3:0] irq_hold);
        vec_t z;
        z = mk(irq_hold, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(z);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 check_rst("reset");
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Behavioural model: outstanding request flag, in-service flag, grant.
    logic [3:0] m_pend, m_mask, m_prev;
    logic       m_ie, m_busy, m_insvc;
    int         m_vec;

    task automatic model_init();
        m_pend = '0; m_mask = '0; m_prev = '1;
        m_ie = 0; m_busy = 0; m_insvc = 0; m_vec = 0;
    endtask

    task automatic model_step(input vec_t v);
        logic [3:0] newreq, np, elig;
        logic       nb, ns;
        int         nv;
`ifdef INTR_CTRL_EDGE_EN
        newreq = v.irq & ~m_prev;
`else
        newreq = v.irq;
`endif
        np = m_pend; nb = m_busy; ns = m_insvc; nv = m_vec;
        elig = m_pend & m_mask;
        if (m_busy) begin
            if (v.ack) begin
                np[m_vec] = 1'b0; nb = 0; ns = 1;
            end else if (!m_ie || !m_mask[m_vec]) begin
                nb = 0;
            end
        end else if (m_insvc) begin
            if (v.retie) ns = 0;
        end else if (m_ie && elig != 0) begin
            nb = 1;
            nv = -1;
            for (int i = 0; i < 4; i++) if (elig[i] && nv < 0) nv = i;
        end
        np = np | newreq;
        if (v.retie)               m_ie = 1;
        else if (v.cli || v.ack)   m_ie = 0;
        else if (v.sei)            m_ie = 1;
        if (v.we) m_mask = v.din;
        m_prev = v.irq;
        m_pend = np; m_busy = nb; m_insvc = ns; m_vec = nv;
    endtask

    vec_t tbl[$];
    vec_t mode_seq[$];

    initial begin
        // mk(irq, we, din, sei, cli, ack, retie,  int, vec, ie, pend)
`ifdef INTR_CTRL_EDGE_EN
        mode_seq.push_back(mk(4'h1, 1, 4'hF, 1, 0, 0, 0,  0, 0, 1, 4'h0));
        mode_seq.push_back(mk(4'h1, 0, 4'h0, 0, 0, 0, 0,  0, 0, 1, 4'h0));
        mode_seq.push_back(mk(4'h1, 0, 4'h0, 0, 0, 0, 0,  0, 0, 1, 4'h0));
        mode_seq.push_back(mk(4'h1, 0, 4'h0, 0, 0, 0, 0,  0, 0, 1, 4'h0));
        mode_seq.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0,  0, 0, 1, 4'h0));
        mode_seq.push_back(mk(4'h1, 0, 4'h0, 0, 0, 0, 0,  0, 0, 1, 4'h1));
        mode_seq.push_back(mk(4'h1, 0, 4'h0, 0, 0, 0, 0,  1, 0, 1, 4'h1));
        mode_seq.push_back(mk(4'h1, 0, 4'h0, 0, 0, 1, 0,  0, 0, 0, 4'h0));
        mode_seq.push_back(mk(4'h1, 0, 4'h0, 0, 0, 0, 1,  0, 0, 1, 4'h0));
        mode_seq.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0,  0, 0, 1, 4'h0));
`else
        mode_seq.push_back(mk(4'h1, 1, 4'hF, 1, 0, 0, 0,  0, 0, 1, 4'h1));
        mode_seq.push_back(mk(4'h1, 0, 4'h0, 0, 0, 0, 0,  1, 0, 1, 4'h1));
        mode_seq.push_back(mk(4'h1, 0, 4'h0, 0, 0, 1, 0,  0, 0, 0, 4'h1));
        mode_seq.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 1,  0, 0, 1, 4'h1));
        mode_seq.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0,  1, 0, 1, 4'h1));
        mode_seq.push_back(mk(4'h0, 0, 4'h0, 0, 0, 1, 0,  0, 0, 0, 4'h0));
        mode_seq.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 1,  0, 0, 1, 4'h0));
`endif
        // Priority, ack/retie, masking, CLI+SEI, set-wins, mask drop in REQ.
        tbl.push_back(mk(4'h0, 1, 4'hF, 1, 0, 0, 0,  0, 0, 1, 4'h0));
        tbl.push_back(mk(4'hA, 0, 4'h0, 0, 0, 0, 0,  0, 0, 1, 4'hA));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0,  1, 1, 1, 4'hA));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0,  1, 1, 1, 4'hA));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 1, 0,  0, 0, 0, 4'h8));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0,  0, 0, 0, 4'h8));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 1,  0, 0, 1, 4'h8));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0,  1, 3, 1, 4'h8));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 1, 0,  0, 0, 0, 4'h0));
        tbl.push_back(mk(4'h0, 0, 4'h0, 1, 0, 0, 0,  0, 0, 1, 4'h0));
        tbl.push_back(mk(4'h4, 0, 4'h0, 0, 0, 0, 0,  0, 0, 1, 4'h4));
        tbl.push_back(mk(4'h0, 1, 4'hB, 0, 0, 0, 0,  0, 0, 1, 4'h4));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 1,  0, 0, 1, 4'h4));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0,  0, 0, 1, 4'h4));
        tbl.push_back(mk(4'h0, 1, 4'hF, 0, 0, 0, 0,  0, 0, 1, 4'h4));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0,  1, 2, 1, 4'h4));
        tbl.push_back(mk(4'h0, 0, 4'h0, 1, 1, 0, 0,  1, 2, 0, 4'h4));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0,  0, 0, 0, 4'h4));
        tbl.push_back(mk(4'h0, 0, 4'h0, 1, 0, 0, 0,  0, 0, 1, 4'h4));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0,  1, 2, 1, 4'h4));
        tbl.push_back(mk(4'h4, 0, 4'h0, 0, 0, 1, 0,  0, 0, 0, 4'h4));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0,  0, 0, 0, 4'h4));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 1,  0, 0, 1, 4'h4));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0,  1, 2, 1, 4'h4));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 1, 0,  0, 0, 0, 4'h0));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 1, 0,  0, 0, 0, 4'h0));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 1,  0, 0, 1, 4'h0));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 1,  0, 0, 1, 4'h0));
        tbl.push_back(mk(4'h1, 0, 4'h0, 0, 0, 0, 0,  0, 0, 1, 4'h1));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0,  1, 0, 1, 4'h1));
        tbl.push_back(mk(4'h0, 1, 4'hE, 0, 0, 0, 0,  1, 0, 1, 4'h1));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0,  0, 0, 1, 4'h1));
        tbl.push_back(mk(4'h0, 1, 4'hF, 0, 0, 0, 0,  0, 0, 1, 4'h1));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 0, 0,  1, 0, 1, 4'h1));
        tbl.push_back(mk(4'h8, 0, 4'h0, 0, 0, 0, 0,  1, 0, 1, 4'h9));
        tbl.push_back(mk(4'h0, 0, 4'h0, 0, 0, 1, 0,  0, 0, 0, 4'h8));
        tbl.push_back(mk(4'h0, 0, 4'h0, 1, 0, 0, 0,  0, 0, 1, 4'h8));

        // Line held high through reset.
        do_reset(4'h1);
        foreach (mode_seq[i]) run(mode_seq[i], $sformatf("mode[%0d]", i));

        do_reset(4'h0);
        foreach (tbl[i]) run(tbl[i], $sformatf("tbl[%0d]", i));

        // Now in SVC with IE=1, PEND=8: reset between edges must act at once.
        #2 RST = 1'b1;
        #1 check_rst("async_rst");
        do_reset(4'h0);

        // Random run against the model.
        model_init();
        for (int c = 0; c < 800; c++) begin
            vec_t rv;
            rv.irq   = ($urandom_range(0, 99) < 30) ? 4'($urandom) : 4'h0;
            rv.we    = ($urandom_range(0, 99) < 10);
            rv.din   = 4'($urandom);
            rv.sei   = ($urandom_range(0, 99) < 20);
            rv.cli   = ($urandom_range(0, 99) < 5);
            rv.ack   = m_busy  ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 3);
            rv.retie = m_insvc ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 3);
            drive(rv);
            model_step(rv);
            @(posedge CLK); #1;
            check("rand", m_busy, 2'(m_vec), m_ie, m_pend);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
